// File: rtl/i2c_cfg_sequencer.sv
// Table-driven I2C register-write sequencer feeding one i2c_master.
// Optional macro I2C_RETRY_EN enables per-entry retries on NACK (up to MAX_RETRY).
module i2c_cfg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned DELAY_UNIT = 50_000,
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_data,
  output logic             i2c_start,
  output logic [6:0]       i2c_addr,
  output logic             i2c_rw,
  output logic [15:0]      i2c_data,
  input  logic             i2c_ready,
  input  logic             i2c_error,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] err_idx
);

  localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, RETRY_CHK, DELAY, NEXT, DONE, FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_q, err_d;
  logic [15:0]      data_q, data_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             go_q;
  logic             go_rise;

`ifdef I2C_RETRY_EN
  localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RT_W-1:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = |MAX_RETRY;
`endif

  assign go_rise = go & ~go_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      data_q  <= '0;
      dly_q   <= '0;
      to_q    <= '0;
      armed_q <= 1'b0;
      pend_q  <= AUTO_START;
      go_q    <= 1'b0;
`ifdef I2C_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      data_q  <= data_d;
      dly_q   <= dly_d;
      to_q    <= to_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      go_q    <= go;
`ifdef I2C_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    data_d  = data_q;
    dly_d   = dly_q;
    to_d    = '0;
    armed_d = 1'b0;
    pend_d  = pend_q;
`ifdef I2C_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (go_rise || (state_q == IDLE && pend_q)) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = FETCH;
`ifdef I2C_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (tbl_data == 16'hFFFF) begin
          state_d = DONE;
        end else if (tbl_data[15:8] == 8'hFE) begin
          if (tbl_data[7:0] == 8'h00) begin
            state_d = NEXT;
          end else begin
            dly_d   = DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
            state_d = DELAY;
          end
        end else begin
          data_d  = tbl_data;
          state_d = ISSUE;
        end
      end
      // Acceptance is ready seen high then low while start is held, so a
      // master still low after reset is not mistaken for an accept.
      ISSUE: begin
        armed_d = armed_q | i2c_ready;
        if (armed_q && !i2c_ready) begin
          state_d = WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = idx_q;
          state_d = FAIL;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (i2c_ready) begin
          state_d = i2c_error ? RETRY_CHK : NEXT;
        end else if (to_q == TO_LAST) begin
          err_d   = idx_q;
          state_d = FAIL;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      RETRY_CHK: begin
`ifdef I2C_RETRY_EN
        if (retry_q < RT_W'(MAX_RETRY)) begin
          retry_d = retry_q + RT_W'(1);
          state_d = ISSUE;
        end else begin
          err_d   = idx_q;
          state_d = FAIL;
        end
`else
        err_d   = idx_q;
        state_d = FAIL;
`endif
      end
      DELAY: begin
        dly_d = dly_q - DLY_W'(1);
        if (dly_q <= DLY_W'(1)) state_d = NEXT;
      end
      NEXT: begin
        if (&idx_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
`ifdef I2C_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tbl_idx   = idx_q;
  assign err_idx   = err_q;
  assign i2c_start = (state_q == ISSUE);
  assign i2c_addr  = DEV_ADDR;
  assign i2c_rw    = 1'b0;
  assign i2c_data  = data_q;
  assign busy      = !(state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign done      = (state_q == DONE);
  assign fail      = (state_q == FAIL);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a registered ROM and a simple master model.
module tb_i2c_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [7:0]  tbl_idx, err_idx;
  logic [15:0] tbl_data;
  logic        i2c_start, i2c_rw, i2c_ready, i2c_error;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        busy, done, fail;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];
  bit          m_en;
  logic [15:0] nack_data;
  int          nack_times;
  int          nack_used;
  logic        m_busy, m_nack;
  int          m_cnt;
  int          bad_addr;
  logic [15:0] xfer_q[$];

  int          ncyc;
  logic        pst, prd;
  int          st_q[$];
  int          rd_q[$];

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(
    .DEV_ADDR(7'h39), .IDX_W(8), .DELAY_UNIT(10), .TIMEOUT(100),
    .AUTO_START(1'b1), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data(i2c_data), .i2c_ready(i2c_ready), .i2c_error(i2c_error),
    .busy(busy), .done(done), .fail(fail), .err_idx(err_idx)
  );

  always @(posedge clk) tbl_data <= rom[tbl_idx];

  // Master: ready when idle, accepts on start, completes 4 clks later.
  always @(posedge clk) begin
    if (rst || !m_en) begin
      i2c_ready <= 1'b0;
      i2c_error <= 1'b0;
      m_busy    <= 1'b0;
      m_nack    <= 1'b0;
      m_cnt     <= 0;
      if (rst) begin
        nack_used <= 0;
        bad_addr  <= 0;
        xfer_q.delete();
      end
    end else if (!m_busy) begin
      i2c_ready <= 1'b1;
      if (i2c_start && i2c_ready) begin
        m_busy    <= 1'b1;
        m_cnt     <= 0;
        i2c_ready <= 1'b0;
        i2c_error <= 1'b0;
        xfer_q.push_back(i2c_data);
        if (i2c_addr !== 7'h39 || i2c_rw !== 1'b0) bad_addr <= bad_addr + 1;
        if (i2c_data == nack_data && nack_used < nack_times) begin
          m_nack    <= 1'b1;
          nack_used <= nack_used + 1;
        end else begin
          m_nack <= 1'b0;
        end
      end
    end else if (m_cnt == 3) begin
      m_busy    <= 1'b0;
      i2c_ready <= 1'b1;
      i2c_error <= m_nack;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (rst) begin
      st_q.delete();
      rd_q.delete();
    end else begin
      if (i2c_start && !pst) st_q.push_back(ncyc);
      if (i2c_ready && !prd) rd_q.push_back(ncyc);
    end
    pst <= i2c_start;
    prd <= i2c_ready;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h4110;
    rom[1] = 16'h9803;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || fail) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(done || fail)) begin
      errors++;
      $display("FAIL wait_end: no done/fail after %0d clks (required within %0d)", n, budget);
    end
  endtask

  task automatic test_reset();
    load_basic();
    m_en = 1'b1; nack_times = 0; nack_data = 16'h0000;
    rst = 1'b1; go = 1'b0;
    repeat (3) tick();
    checks++;
    if ({i2c_start, busy, done, fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {i2c_start, busy, done, fail});
    end
    checks++;
    if (tbl_idx !== 8'd0 || err_idx !== 8'd0 || i2c_data !== 16'h0000) begin
      errors++; $display("FAIL reset_regs: got idx=%h err=%h data=%h expected 0/0/0", tbl_idx, err_idx, i2c_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || tbl_idx !== 8'd0) begin
      errors++; $display("FAIL auto_start: got busy=%b idx=%h expected 1/00", busy, tbl_idx);
    end
  endtask

  task automatic test_basic();
    load_basic();
    do_reset();
    wait_end(2000);
    checks++;
    if (xfer_q.size() !== 2) begin
      errors++; $display("FAIL basic_count: got %0d expected 2", xfer_q.size());
    end else begin
      checks++;
      if (xfer_q[0] !== 16'h4110 || xfer_q[1] !== 16'h9803) begin
        errors++; $display("FAIL basic_data: got %h,%h expected 4110,9803", xfer_q[0], xfer_q[1]);
      end
    end
    checks++;
    if ({done, busy, fail} !== 3'b100 || tbl_idx !== 8'd2) begin
      errors++; $display("FAIL basic_status: got dbf=%b idx=%h expected 100/02", {done, busy, fail}, tbl_idx);
    end
    checks++;
    if (bad_addr !== 0 || i2c_data !== 16'h9803) begin
      errors++; $display("FAIL basic_addr: got bad=%0d data=%h expected 0/9803", bad_addr, i2c_data);
    end
    checks++;
    if (st_q.size() < 2 || rd_q.size() < 2) begin
      errors++; $display("FAIL basic_timing: got %0d starts %0d readies expected >=2", st_q.size(), rd_q.size());
    end else begin
      checks++;
      if (st_q[0] - rd_q[0] !== 2 || st_q[1] - rd_q[1] !== 4) begin
        errors++; $display("FAIL basic_gap: got %0d,%0d expected 2,4", st_q[0] - rd_q[0], st_q[1] - rd_q[1]);
      end
    end
  endtask

  task automatic test_delay();
    load_basic();
    rom[1] = 16'hFE02;
    rom[2] = 16'hFE00;
    rom[3] = 16'h9803;
    do_reset();
    wait_end(2000);
    checks++;
    if (xfer_q.size() !== 2 || done !== 1'b1 || tbl_idx !== 8'd4) begin
      errors++; $display("FAIL delay_status: got n=%0d done=%b idx=%h expected 2/1/04", xfer_q.size(), done, tbl_idx);
    end else begin
      checks++;
      if (xfer_q[1] !== 16'h9803) begin
        errors++; $display("FAIL delay_data: got %h expected 9803", xfer_q[1]);
      end
    end
    checks++;
    if (st_q.size() < 2 || rd_q.size() < 2) begin
      errors++; $display("FAIL delay_timing: got %0d starts expected 2", st_q.size());
    end else begin
      checks++;
      // 3 clks to DELAY, 20 in DELAY, 3 through FE00 no-op, 3 to ISSUE, +1 NEXT
      if (st_q[1] - rd_q[1] !== 30) begin
        errors++; $display("FAIL delay_gap: got %0d expected 30", st_q[1] - rd_q[1]);
      end
    end
  endtask

  task automatic test_nack();
    load_basic();
    nack_data = 16'h9803; nack_times = 1;
    do_reset();
    wait_end(2000);
`ifdef I2C_RETRY_EN
    checks++;
    if (xfer_q.size() !== 3 || done !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL retry_status: got n=%0d done=%b fail=%b expected 3/1/0", xfer_q.size(), done, fail);
    end else begin
      checks++;
      if (xfer_q[1] !== 16'h9803 || xfer_q[2] !== 16'h9803) begin
        errors++; $display("FAIL retry_data: got %h,%h expected 9803,9803", xfer_q[1], xfer_q[2]);
      end
    end
`else
    checks++;
    if (xfer_q.size() !== 2 || fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nack_status: got n=%0d fail=%b done=%b busy=%b expected 2/1/0/0", xfer_q.size(), fail, done, busy);
    end
    checks++;
    if (err_idx !== 8'd1) begin
      errors++; $display("FAIL nack_err_idx: got %h expected 01", err_idx);
    end
`endif
    nack_times = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    int starts = 0;
    load_basic();
    m_en = 1'b0;
    do_reset();
    while (!fail && n < 400) begin
      tick();
      if (i2c_start) starts++;
      n++;
    end
    checks++;
    if (fail !== 1'b1 || starts !== 100) begin
      errors++; $display("FAIL timeout_len: got fail=%b start_clks=%0d expected 1/100", fail, starts);
    end
    checks++;
    if (i2c_start !== 1'b0 || busy !== 1'b0 || err_idx !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL timeout_out: got start=%b busy=%b err=%h done=%b expected 0/0/00/0", i2c_start, busy, err_idx, done);
    end
    m_en = 1'b1;
  endtask

  task automatic test_go();
    int n = 0;
    load_basic();
    do_reset();
    while (st_q.size() < 2 && n < 500) begin tick(); n++; end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (busy !== 1'b1 || tbl_idx !== 8'd1) begin
      errors++; $display("FAIL go_busy: got busy=%b idx=%h expected 1/01", busy, tbl_idx);
    end
    wait_end(2000);
    checks++;
    if (xfer_q.size() !== 2 || done !== 1'b1) begin
      errors++; $display("FAIL go_ignored: got n=%0d done=%b expected 2/1", xfer_q.size(), done);
    end
    go = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || tbl_idx !== 8'd0) begin
      errors++; $display("FAIL go_restart: got done=%b busy=%b idx=%h expected 0/1/00", done, busy, tbl_idx);
    end
    go = 1'b0;
    wait_end(2000);
    checks++;
    if (xfer_q.size() !== 4 || done !== 1'b1) begin
      errors++; $display("FAIL go_rerun: got n=%0d done=%b expected 4/1", xfer_q.size(), done);
    end else begin
      checks++;
      if (xfer_q[2] !== 16'h4110 || xfer_q[3] !== 16'h9803) begin
        errors++; $display("FAIL go_rerun_data: got %h,%h expected 4110,9803", xfer_q[2], xfer_q[3]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    load_basic();
    do_reset();
    while (!(st_q.size() == 2 && !i2c_start && busy) && n < 500) begin tick(); n++; end
    checks++;
    if (tbl_idx !== 8'd1 || i2c_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_setup: got idx=%h start=%b expected 01/0", tbl_idx, i2c_start);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (i2c_start !== 1'b0 || busy !== 1'b0 || tbl_idx !== 8'd0 || i2c_data !== 16'h0000) begin
      errors++; $display("FAIL rst_mid: got start=%b busy=%b idx=%h data=%h expected 0/0/00/0000", i2c_start, busy, tbl_idx, i2c_data);
    end
    tick();
    rst = 1'b0;
    wait_end(2000);
    checks++;
    if (xfer_q.size() !== 2 || done !== 1'b1) begin
      errors++; $display("FAIL rst_restart: got n=%0d done=%b expected 2/1", xfer_q.size(), done);
    end else begin
      checks++;
      if (xfer_q[0] !== 16'h4110) begin
        errors++; $display("FAIL rst_restart_data: got %h expected 4110", xfer_q[0]);
      end
    end
  endtask

  initial begin
    ncyc = 0;
    rst = 1'b1;
    go = 1'b0;
    m_en = 1'b1;
    nack_data = 16'h0000;
    nack_times = 0;
    test_reset();
    test_basic();
    test_delay();
    test_nack();
    test_timeout();
    test_go();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
